// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch stage with one-outstanding-request memory port
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
);

  // REQ: request on the bus; WAIT: accepted, awaiting data;
  // HELD: instruction presented to decode; DISCARD: draining an abandoned request
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HELD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = {PCTargetE[31:2], 2'b00};

  // Request is gated by rst_n so nothing is issued while the core is held in reset
  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc;

  // Fetch FSM: a redirect wins over stall in every state; an already
  // committed request is drained through DISCARD so its data never surfaces
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      validF   <= 1'b0;
      instrF   <= NOP_INSTR;
      PCF      <= RESET_PC;
      PCPlus4F <= RESET_PC + 32'd4;
    end else if (PCSrcE) begin
      pc     <= redirect_pc;
      validF <= 1'b0;
      instrF <= NOP_INSTR;
      case (state)
        S_REQ:     state <= imem_ready  ? S_DISCARD : S_REQ;
        S_WAIT:    state <= imem_rvalid ? S_REQ     : S_DISCARD;
        S_HELD:    state <= S_REQ;
        S_DISCARD: state <= imem_rvalid ? S_REQ     : S_DISCARD;
        default:   state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instrF   <= imem_rdata;
            PCF      <= pc;
            PCPlus4F <= pc_plus4;
            validF   <= 1'b1;
            state    <= S_HELD;
          end
        end
        S_HELD: begin
          if (!stallF) begin
            pc     <= pc_plus4;
            validF <= 1'b0;
            instrF <= NOP_INSTR;
            state  <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RP  = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrF, PCF, PCPlus4F;
  logic        validF;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(RP), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall, pcsrc;
    logic [31:0] target;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pcf;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                              input logic rd, input logic rv, input logic [31:0] d,
                              input logic rq, input logic [31:0] a, input logic v,
                              input logic [31:0] ins, input logic [31:0] pcf);
    vec_t r;
    r.stall = s; r.pcsrc = p; r.target = t; r.ready = rd; r.rvalid = rv; r.rdata = d;
    r.e_req = rq; r.e_addr = a; r.e_valid = v; r.e_instr = ins; r.e_pcf = pcf;
    return r;
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check_outputs(input string tag, input logic rq, input logic [31:0] a,
                               input logic v, input logic [31:0] ins, input logic [31:0] pcf);
    check({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, rq});
    check({tag, ".imem_addr"}, imem_addr, a);
    check({tag, ".validF"},    {31'd0, validF}, {31'd0, v});
    check({tag, ".instrF"},    instrF, ins);
    check({tag, ".PCF"},       PCF, pcf);
    check({tag, ".PCPlus4F"},  PCPlus4F, pcf + 32'd4);
  endtask

  vec_t vt[23];

  // behavioural model state
  logic [31:0] m_pc, m_pcf, m_instr;
  logic        m_slot, m_pend, m_stale;
  logic [31:0] m_pend_addr;
  // memory responder state
  logic        mem_pend;
  logic [31:0] mem_addr_q;
  int          mem_cnt;

  initial begin
    // cycle-by-cycle directed table (inputs, then expected state seen during that cycle)
    vt[0]  = mk(0,0,0,            1,0,0,            1, RP,           0, NOP,          RP);
    vt[1]  = mk(0,0,0,            0,1,32'h00500093, 0, RP,           0, NOP,          RP);
    vt[2]  = mk(1,0,0,            0,0,0,            0, RP,           1, 32'h00500093, RP);
    vt[3]  = mk(1,0,0,            0,0,0,            0, RP,           1, 32'h00500093, RP);
    vt[4]  = mk(1,0,0,            0,0,0,            0, RP,           1, 32'h00500093, RP);
    vt[5]  = mk(1,0,0,            0,0,0,            0, RP,           1, 32'h00500093, RP);
    vt[6]  = mk(0,0,0,            0,0,0,            0, RP,           1, 32'h00500093, RP);
    vt[7]  = mk(0,0,0,            0,0,0,            1, RP+4,         0, NOP,          RP);
    vt[8]  = mk(0,0,0,            1,0,0,            1, RP+4,         0, NOP,          RP);
    vt[9]  = mk(0,1,32'h00000102, 0,0,0,            0, RP+4,         0, NOP,          RP);
    vt[10] = mk(0,0,0,            0,0,0,            0, 32'h100,      0, NOP,          RP);
    vt[11] = mk(0,0,0,            0,1,32'hDEADBEEF, 0, 32'h100,      0, NOP,          RP);
    vt[12] = mk(0,0,0,            1,0,0,            1, 32'h100,      0, NOP,          RP);
    vt[13] = mk(0,1,32'h00000200, 0,1,32'h11111111, 0, 32'h100,      0, NOP,          RP);
    vt[14] = mk(0,1,32'h00000300, 1,0,0,            1, 32'h200,      0, NOP,          RP);
    vt[15] = mk(0,0,0,            0,1,32'h22222222, 0, 32'h300,      0, NOP,          RP);
    vt[16] = mk(0,0,0,            1,0,0,            1, 32'h300,      0, NOP,          RP);
    vt[17] = mk(0,0,0,            0,1,32'h33333333, 0, 32'h300,      0, NOP,          RP);
    vt[18] = mk(1,1,32'hFFFFFFFE, 0,0,0,            0, 32'h300,      1, 32'h33333333, 32'h300);
    vt[19] = mk(0,0,0,            1,0,0,            1, 32'hFFFFFFFC, 0, NOP,          32'h300);
    vt[20] = mk(0,0,0,            0,1,32'h44444444, 0, 32'hFFFFFFFC, 0, NOP,          32'h300);
    vt[21] = mk(0,0,0,            0,0,0,            0, 32'hFFFFFFFC, 1, 32'h44444444, 32'hFFFFFFFC);
    vt[22] = mk(0,0,0,            0,0,0,            1, 32'h0,        0, NOP,          32'hFFFFFFFC);

    rst_n = 1'b0; stallF = 0; PCSrcE = 0; PCTargetE = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    @(negedge clk); @(negedge clk);
    check_outputs("reset", 1'b0, RP, 1'b0, NOP, RP);

    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      stallF = vt[i].stall; PCSrcE = vt[i].pcsrc; PCTargetE = vt[i].target;
      imem_ready = vt[i].ready; imem_rvalid = vt[i].rvalid; imem_rdata = vt[i].rdata;
      #1;
      check_outputs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr,
                    vt[i].e_valid, vt[i].e_instr, vt[i].e_pcf);
      @(negedge clk);
    end

    // asynchronous reset while WAITing on an accepted request
    stallF = 0; PCSrcE = 0; imem_ready = 1; imem_rvalid = 0;
    @(negedge clk);
    imem_ready = 0;
    #2 rst_n = 1'b0;
    #1 check_outputs("async_rst", 1'b0, RP, 1'b0, NOP, RP);
    @(negedge clk);
    imem_rvalid = 1; imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    imem_rvalid = 0; rst_n = 1'b1;
    #1 check_outputs("rst_restart", 1'b1, RP, 1'b0, NOP, RP);

    // randomized phase against the behavioural model
    m_pc = RP; m_pcf = RP; m_instr = NOP; m_slot = 0; m_pend = 0; m_stale = 0; m_pend_addr = 0;
    mem_pend = 0; mem_addr_q = 0; mem_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      logic acc, rsp, cons, exp_req;
      @(negedge clk);
      stallF     = ($urandom % 4) == 0;
      PCSrcE     = ($urandom % 12) == 0;
      PCTargetE  = (($urandom % 4) == 0) ? (32'hFFFFFFF0 | $urandom) : $urandom;
      imem_ready = $urandom % 2;
      imem_rvalid = mem_pend && (mem_cnt == 0);
      imem_rdata = imem_rvalid ? mem_data(mem_addr_q) : $urandom;
      #1;
      exp_req = !m_slot && !m_pend;
      if (c < 40 || (c % 7) == 0)
        check_outputs("rand", exp_req, m_pc, m_slot, m_slot ? m_instr : NOP, m_pcf);
      else begin
        check("rand.imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("rand.imem_addr", imem_addr, m_pc);
        check("rand.instrF", instrF, m_slot ? m_instr : NOP);
      end

      // model: request acceptance, response, consumption, redirect
      acc  = exp_req && imem_ready;
      rsp  = imem_rvalid && m_pend;
      cons = m_slot && !stallF && !PCSrcE;
      if (rsp) begin
        m_pend = 0;
        if (!m_stale && !PCSrcE) begin
          m_slot = 1; m_instr = imem_rdata; m_pcf = m_pend_addr;
        end
      end
      if (acc) begin
        m_pend = 1; m_pend_addr = m_pc; m_stale = PCSrcE;
      end
      if (cons) begin
        m_slot = 0; m_pc = m_pc + 32'd4;
      end
      if (PCSrcE) begin
        m_pc = PCTargetE & 32'hFFFFFFFC; m_slot = 0; m_stale = 1;
      end

      // memory responder: latency 1..3 cycles after acceptance
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (imem_req && imem_ready) begin
        mem_pend = 1; mem_addr_q = imem_addr; mem_cnt = $urandom % 3;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch-side producer for the F->D pipeline register. Owns the PC, issues one-outstanding-request reads to instruction memory over a ready/valid handshake, and presents instrF/PCF/PCPlus4F to the F->D pipeline register. Honours stallF from the hazard unit and redirects from execute (PCSrcE/PCTargetE). Whenever no instruction is available it presents a NOP bubble.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset
NOP_INSTR, 32'h00000013, instruction driven on instrF when validF=0

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
stallF  input  1  hazard unit hold; 1 = decode not accepting this cycle
PCSrcE  input  1  redirect request from execute
PCTargetE  input  32  redirect target
imem_req  output  1  read request valid
imem_addr  output  32  read address (word aligned)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
instrF  output  32  fetched instruction (NOP_INSTR when not valid)
PCF  output  32  address of instrF
PCPlus4F  output  32  PCF+4
validF  output  1  instrF holds a real fetched instruction

Behaviour:
- Reset (async on rst_n low, any state, including mid-request): state=REQ, PC=RESET_PC, validF=0, instrF=NOP_INSTR, PCF=RESET_PC, PCPlus4F=RESET_PC+4. imem_req=0 while rst_n=0. Any response to a request issued before reset is ignored; the memory is reset with the core.
- States: REQ, WAIT, HELD, DISCARD.
- REQ: imem_req=1, imem_addr=PC. On imem_ready=1 -> WAIT. Until accepted, imem_req/imem_addr may change (redirect). Request is committed only on imem_ready.
- WAIT: imem_req=0. On imem_rvalid=1: capture instrF<=imem_rdata, PCF<=PC, PCPlus4F<=PC+4, validF<=1, -> HELD.
- HELD: imem_req=0, outputs stable. stallF=0 consumes the instruction: PC<=PC+4, validF<=0, instrF<=NOP_INSTR, -> REQ. stallF=1: hold everything.
- DISCARD: imem_req=0. Waits for the response to an abandoned request. On imem_rvalid the data is dropped -> REQ.
- Redirect: PCSrcE=1 beats stallF in every state. PC<=PCTargetE with bits[1:0] forced to 0. validF<=0 and instrF<=NOP_INSTR next cycle.
  - REQ with imem_ready=0: stay REQ; new address is driven next cycle.
  - REQ with imem_ready=1: the old address was committed -> DISCARD.
  - WAIT with imem_rvalid=0 -> DISCARD.
  - WAIT with imem_rvalid=1: data dropped -> REQ.
  - HELD: held instruction dropped -> REQ.
  - DISCARD: PC updated, stay DISCARD; if imem_rvalid the same cycle -> REQ.
- Memory contract: imem_rvalid is asserted exactly once per accepted request, earliest the cycle after acceptance. imem_rvalid outside WAIT/DISCARD is a protocol error and is ignored.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFFFFFC+4 = 0.
- Throughput: with 1-cycle memory latency and no stalls, one instruction per 3 cycles (REQ, WAIT, HELD). validF is high only in HELD.
- All outputs are registered except imem_req and imem_addr, which are decoded from state and PC.

Test Plan:
- Reset then 1-cycle memory returning 0x00500093 at 0xBFC00000 -> imem_addr=0xBFC00000 in cycle 1. validF=1, instrF=0x00500093, PCF=0xBFC00000, PCPlus4F=0xBFC00004 in cycle 3. Next request to 0xBFC00004.
- stallF=1 for 4 cycles while HELD -> instrF/PCF/validF unchanged and imem_req=0 for 4 cycles. Release stallF -> PC advances by exactly 4.
- Redirect in WAIT (PCSrcE=1, PCTargetE=0x00000102, rvalid 2 cycles later with 0xDEADBEEF) -> 0xDEADBEEF never appears on instrF. The next request address is 0x00000100.
- Redirect in the same cycle as imem_rvalid in WAIT, and separately in the same cycle as imem_ready in REQ -> respectively: immediate REQ at target; DISCARD then REQ at target. No stale instruction reaches validF=1.
- rst_n pulsed low during WAIT -> outputs return to reset values asynchronously. Fetch restarts at RESET_PC.
- PC=0xFFFFFFFC consumed -> PCPlus4F=0x00000000 and the next imem_addr=0x00000000.
